// File: rtl/rcs_pipe_sub.sv
// rcs_pipe_sub: pipelined unsigned subtractor (A - B = A + ~B + 1).
// The borrow chain is cut into STAGES slices, one slice resolved per
// register stage, with a collapsing valid/ready chain for backpressure.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; the producer holds its payload stable until that edge, and
// the payload is ignored whenever valid is low.
module rcs_pipe_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A_32,
    input  logic [WIDTH-1:0] B_32,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff32,
    output logic             Borrow,
    output logic             Zero
);

    localparam int SW = WIDTH / STAGES;

    // Per-stage state
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_diff   [STAGES];
    logic [WIDTH-1:0]  r_a      [STAGES];
    logic [WIDTH-1:0]  r_nb     [STAGES];
    logic              r_borrow [STAGES];
    logic              r_zero   [STAGES];

    // What each stage would load this cycle
    logic [STAGES:0]   w_ready;
    logic              w_src_valid [STAGES];
    logic [WIDTH-1:0]  w_src_a     [STAGES];
    logic [WIDTH-1:0]  w_src_nb    [STAGES];
    logic [WIDTH-1:0]  w_src_diff  [STAGES];
    logic              w_src_zero  [STAGES];
    logic              w_cin       [STAGES];
    logic [SW:0]       w_sum       [STAGES];
    logic [WIDTH-1:0]  w_diff_next [STAGES];

    assign w_ready[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Stage 0 takes operands straight from the input port; the +1 of
            // the two's complement enters as the initial carry.
            assign w_src_valid[k] = in_valid;
            assign w_src_a[k]     = A_32;
            assign w_src_nb[k]    = ~B_32;
            assign w_src_diff[k]  = '0;
            assign w_src_zero[k]  = 1'b1;
            assign w_cin[k]       = 1'b1;
        end else begin : g_rest
            // Later stages continue from the predecessor; carry = ~borrow.
            assign w_src_valid[k] = r_valid[k-1];
            assign w_src_a[k]     = r_a[k-1];
            assign w_src_nb[k]    = r_nb[k-1];
            assign w_src_diff[k]  = r_diff[k-1];
            assign w_src_zero[k]  = r_zero[k-1];
            assign w_cin[k]       = ~r_borrow[k-1];
        end

        // A stage can take new data if it is empty or everything after it
        // can move; written as a flat reduction so the chain has no loop.
        assign w_ready[k] = out_ready | ~(&r_valid[STAGES-1:k]);

        // Slice k of A + ~B + carry-in, with carry-out in the top bit
        assign w_sum[k] = {1'b0, w_src_a[k][k*SW +: SW]}
                        + {1'b0, w_src_nb[k][k*SW +: SW]}
                        + {{SW{1'b0}}, w_cin[k]};

        // Slices k and above of the incoming partial result are still zero,
        // so OR-ing the new slice into place is enough.
        assign w_diff_next[k] = w_src_diff[k] | (WIDTH'(w_sum[k][SW-1:0]) << (k*SW));
    end

    assign in_ready  = w_ready[0] & rst_n;
    assign out_valid = r_valid[STAGES-1];
    assign Diff32    = r_diff[STAGES-1];
    assign Borrow    = r_borrow[STAGES-1];
    assign Zero      = r_zero[STAGES-1];

    // Stage registers: advance when ready, load payload only with a valid op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k]  <= 1'b0;
                r_diff[k]   <= '0;
                r_a[k]      <= '0;
                r_nb[k]     <= '0;
                r_borrow[k] <= 1'b0;
                r_zero[k]   <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_src_valid[k];
                    if (w_src_valid[k]) begin
                        r_diff[k]   <= w_diff_next[k];
                        r_a[k]      <= w_src_a[k];
                        r_nb[k]     <= w_src_nb[k];
                        r_borrow[k] <= ~w_sum[k][SW];
                        r_zero[k]   <= w_src_zero[k] & (w_sum[k][SW-1:0] == '0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rcs_pipe_sub.sv
// tb_rcs_pipe_sub: directed and randomized checks of rcs_pipe_sub against an
// arithmetic reference model with an in-order expected queue.
module tb_rcs_pipe_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A_32;
  logic [31:0] B_32;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Diff32;
  logic        Borrow;
  logic        Zero;

  int checks;
  int errors;

  // {borrow, zero, diff}
  logic [33:0] exp_q[$];
  logic [31:0] op_a[16];
  logic [31:0] op_b[16];

  rcs_pipe_sub #(.WIDTH(32), .STAGES(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A_32     (A_32),
    .B_32     (B_32),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff32   (Diff32),
    .Borrow   (Borrow),
    .Zero     (Zero)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: plain unsigned subtraction and comparisons
  function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return {(a < b), (a == b), d};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    A_32 = 32'h1234;
    B_32 = 32'h1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if ({Borrow, Zero, Diff32} !== 34'h0) begin
      errors++; $display("FAIL reset_outputs got b=%b z=%b d=%h want all 0", Borrow, Zero, Diff32);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  // one op into an empty pipe; checks latency, single-cycle out_valid, values
  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_d, input logic exp_b, input logic exp_z,
                          input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    A_32 = a;
    B_32 = b;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b want 1", tag, in_ready); end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== (i == 4)) begin
        errors++; $display("FAIL %s out_valid cycle %0d got %b want %b", tag, i, out_valid, (i == 4));
      end
      if (i == 4) begin
        checks++;
        if (Diff32 !== exp_d || Borrow !== exp_b || Zero !== exp_z) begin
          errors++;
          $display("FAIL %s result got d=%h b=%b z=%b want d=%h b=%b z=%b",
                   tag, Diff32, Borrow, Zero, exp_d, exp_b, exp_z);
        end
      end
    end
  endtask

  task automatic test_directed();
    send_one(32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b0, "small");
    send_one(32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, "wrap");
    send_one(32'h01000000, 32'h00000001, 32'h00FFFFFF, 1'b0, 1'b0, "borrow_chain");
    send_one(32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, "equal");
    send_one(32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "msb");
  endtask

  // 16-op stream; rand_ready=1 toggles out_ready with a 6-cycle low run every 12
  task automatic run_stream(input bit rand_ready, input string tag);
    int sent, got, cyc, first_out, last_out, stall_in;
    bit pending, was_stalled;
    logic [31:0] cur_a, cur_b, prev_d;
    logic prev_b, prev_z;
    logic [33:0] exp;
    sent = 0; got = 0; cyc = 0; first_out = -1; last_out = -1; stall_in = 0;
    pending = 1'b0; was_stalled = 1'b0;
    cur_a = '0; cur_b = '0; prev_d = '0; prev_b = 1'b0; prev_z = 1'b0;
    while (got < 16 && cyc < 400) begin
      @(negedge clk);
      if (!pending && sent < 16) begin
        cur_a = op_a[sent];
        cur_b = op_b[sent];
        pending = 1'b1;
      end
      in_valid = pending;
      A_32 = cur_a;
      B_32 = cur_b;
      if (rand_ready)
        out_ready = ((cyc % 12) >= 4 && (cyc % 12) <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
      else
        out_ready = 1'b1;
      #1;
      if (was_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || Diff32 !== prev_d || Borrow !== prev_b || Zero !== prev_z) begin
          errors++;
          $display("FAIL %s hold cycle %0d got v=%b d=%h b=%b z=%b want v=1 d=%h b=%b z=%b",
                   tag, cyc, out_valid, Diff32, Borrow, Zero, prev_d, prev_b, prev_z);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(cur_a, cur_b));
        pending = 1'b0;
        sent++;
      end else if (in_valid) begin
        stall_in++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_output d=%h with empty queue", tag, Diff32);
        end else begin
          exp = exp_q.pop_front();
          if ({Borrow, Zero, Diff32} !== exp) begin
            errors++;
            $display("FAIL %s result %0d got b=%b z=%b d=%h want b=%b z=%b d=%h",
                     tag, got, Borrow, Zero, Diff32, exp[33], exp[32], exp[31:0]);
          end
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
      end
      was_stalled = out_valid && !out_ready;
      prev_d = Diff32;
      prev_b = Borrow;
      prev_z = Zero;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != 16) begin errors++; $display("FAIL %s timeout got %0d results want 16", tag, got); end
    if (!rand_ready) begin
      checks++;
      if (first_out != 4 || last_out != 19) begin
        errors++; $display("FAIL %s timing first=%0d last=%0d want 4 and 19", tag, first_out, last_out);
      end
    end else begin
      checks++;
      if (stall_in == 0) begin errors++; $display("FAIL %s in_ready never dropped got 0 stalls want >0", tag); end
    end
    repeat (6) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s drain out_valid got %b want 0", tag, out_valid); end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL %s leftover got %0d pending want 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    run_stream(1'b0, "stream");
  endtask

  task automatic test_backpressure();
    run_stream(1'b1, "backpressure");
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      A_32 = op_a[i];
      B_32 = op_b[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset in_ready got %b want 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || {Borrow, Zero, Diff32} !== 34'h0) begin
        errors++;
        $display("FAIL midreset quiet cycle %0d got v=%b b=%b z=%b d=%h want all 0",
                 i, out_valid, Borrow, Zero, Diff32);
      end
      @(negedge clk);
    end
    send_one(32'd10, 32'd20, 32'hFFFFFFF6, 1'b1, 1'b0, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    A_32 = '0;
    B_32 = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op_a[i] = $urandom();
      op_b[i] = (i % 4 == 0) ? op_a[i] : $urandom();
    end
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
